// File: rtl/queue_ctrl.sv
// queue_ctrl: occupancy counter with event arbitration, rejection alarm and wait estimate; QUEUE_STATS_EN adds served_total.
// Latency: pcount 1 cycle after sensor edge, wait_time 1 more; no backpressure, one event per input every 2 cycles.
module queue_ctrl #(
  parameter int CAPACITY   = 7,
  parameter int TSVC       = 3,
  parameter int ALARM_HOLD = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enter_req,
  input  logic       exit_req,
  output logic [3:0] pcount,
  output logic [7:0] wait_time,
  output logic       full,
  output logic       empty,
  output logic       alarm,
  output logic [7:0] served_total
);

  typedef enum logic {IDLE, ALARM} state_t;

  localparam logic [3:0] CAP       = 4'(CAPACITY);
  localparam logic [3:0] HOLD_INIT = 4'(ALARM_HOLD - 1);
  localparam logic [7:0] TSVC_W    = 8'(TSVC);

  state_t     state, state_nxt;
  logic [3:0] hold, hold_nxt;
  logic [3:0] pcount_nxt;
  logic       enter_prev, exit_prev;
  logic       ent, ext, reject;

  // prev registers reset high so a level already asserted at reset release is ignored
  assign ent = enter_req & ~enter_prev;
  assign ext = exit_req & ~exit_prev;

  always_comb begin
    pcount_nxt = pcount;
    reject     = 1'b0;
    case ({ent, ext})
      2'b10: begin
        if (pcount < CAP) pcount_nxt = pcount + 4'd1;
        else              reject     = 1'b1;
      end
      2'b01: begin
        if (pcount != 4'd0) pcount_nxt = pcount - 4'd1;
        else                reject     = 1'b1;
      end
      default: pcount_nxt = pcount;
    endcase
  end

  always_comb begin
    state_nxt = state;
    hold_nxt  = hold;
    case (state)
      IDLE: begin
        if (reject) begin
          state_nxt = ALARM;
          hold_nxt  = HOLD_INIT;
        end
      end
      ALARM: begin
        if (reject)              hold_nxt  = HOLD_INIT;
        else if (hold == 4'd0)   state_nxt = IDLE;
        else                     hold_nxt  = hold - 4'd1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      enter_prev <= 1'b1;
      exit_prev  <= 1'b1;
      pcount     <= 4'd0;
      wait_time  <= 8'd0;
      state      <= IDLE;
      hold       <= 4'd0;
    end else begin
      enter_prev <= enter_req;
      exit_prev  <= exit_req;
      pcount     <= pcount_nxt;
      wait_time  <= 8'(pcount) * TSVC_W;
      state      <= state_nxt;
      hold       <= hold_nxt;
    end
  end

  assign full  = (pcount == CAP);
  assign empty = (pcount == 4'd0);
  assign alarm = (state == ALARM);

`ifdef QUEUE_STATS_EN
  logic dec;
  assign dec = ext & ~ent & (pcount != 4'd0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)   served_total <= 8'd0;
    else if (dec) served_total <= served_total + 8'd1;
  end
`else
  assign served_total = 8'd0;
`endif

endmodule
